// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and FSM state types
//
// Purpose: response encodings, response type and the write/read channel state
// enums used by the AXI-Lite register file and its interface.
// Ports: none (package).

package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {
    WIDLE,
    WRESP
  } w_state_t;

  typedef enum logic {
    RIDLE,
    RRESP
  } r_state_t;

endpackage

// File: rtl/axi_lite_reg_file_if.sv
// rtl/axi_lite_reg_file_if.sv - AXI4-Lite bus bundle with master/slave views
//
// Purpose: groups the five AXI-Lite channels (AW, W, B, AR, R) into one bundle.
// Ports (per modport):
//   master - drives aw_*, w_*, ar_* payload/valid and b_ready, r_ready
//   slave  - drives aw_ready, w_ready, b_*, ar_ready, r_* payload/valid

interface axi_lite_reg_file_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import axi_lite_pkg::*;

  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  resp_t                   b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready,
           r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready,
           r_data, r_resp, r_valid
  );

endinterface

// File: rtl/axi_lite_reg_file.sv
// rtl/axi_lite_reg_file.sv - AXI4-Lite slave register file with hardware update port
//
// Purpose: NUM_REGS bus-visible registers with byte-strobe writes, a per-register
// read-only mask and a per-register hardware load port. One outstanding read
// and one outstanding write, each answered with a registered response.
// Ports:
//   Clk_CI       - clock
//   Rst_RBI      - synchronous active-low reset
//   bus          - AXI-Lite slave bundle (AW, W, B, AR, R)
//   HwWrEn_SI    - per-register hardware load enable
//   HwWrData_DI  - hardware load data, register i in slice i
//   Reg_DO       - current register contents, register i in slice i

module axi_lite_reg_file
  import axi_lite_pkg::*;
#(
  parameter int                  AXI_ADDR_WIDTH = 32,
  parameter int                  AXI_DATA_WIDTH = 32,
  parameter int                  NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0] READ_ONLY_MASK = '0
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RBI,
  axi_lite_reg_file_if.slave                 bus,
  input  logic [NUM_REGS-1:0]                HwWrEn_SI,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] HwWrData_DI,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] Reg_DO
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(NUM_REGS * BYTES);

  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] reg_nxt;

  // ---------------- write channel ----------------
  w_state_t w_state, w_state_nxt;
  logic     w_fire;
  logic     w_oor;
  logic     w_ro;
  logic     w_err;
  logic [IDXW-1:0] w_idx;
  resp_t    b_resp_q;

  // The index only matters when the address is in range, so taking the low
  // IDXW bits of the word address is enough.
  assign w_oor = (bus.aw_addr >= SPAN);
  assign w_idx = IDXW'(bus.aw_addr >> OFFS);
  assign w_ro  = !w_oor && READ_ONLY_MASK[w_idx];
  assign w_err = w_oor || w_ro;

  // AW and W are only accepted together; one valid alone never handshakes.
  assign w_fire = (w_state == WIDLE) && bus.aw_valid && bus.w_valid;

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      w_state  <= WIDLE;
      b_resp_q <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      if (w_fire) begin
        b_resp_q <= w_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      WIDLE: if (w_fire) w_state_nxt = WRESP;
      WRESP: if (bus.b_ready) w_state_nxt = WIDLE;
      default: w_state_nxt = WIDLE;
    endcase
  end

  assign bus.aw_ready = w_fire;
  assign bus.w_ready  = w_fire;
  assign bus.b_valid  = (w_state == WRESP);
  assign bus.b_resp   = b_resp_q;

  // ---------------- read channel ----------------
  r_state_t r_state, r_state_nxt;
  logic     r_fire;
  logic     r_oor;
  logic [IDXW-1:0] r_idx;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  resp_t    r_resp_q;

  assign r_oor  = (bus.ar_addr >= SPAN);
  assign r_idx  = IDXW'(bus.ar_addr >> OFFS);
  assign r_fire = (r_state == RIDLE) && bus.ar_valid;

  // Read data is sampled from the current flops, so a write landing on the
  // same edge is not visible to a read accepted on that edge.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_state  <= RIDLE;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (r_fire) begin
        r_data_q <= r_oor ? '0 : regs[r_idx];
        r_resp_q <= r_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      RIDLE: if (r_fire) r_state_nxt = RRESP;
      RRESP: if (bus.r_ready) r_state_nxt = RIDLE;
      default: r_state_nxt = RIDLE;
    endcase
  end

  assign bus.ar_ready = (r_state == RIDLE);
  assign bus.r_valid  = (r_state == RRESP);
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;

  // ---------------- register storage ----------------
  // Per byte: a strobed bus write wins, otherwise the hardware load applies
  // to the whole word, otherwise the byte holds.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic wr_sel;
    assign wr_sel = w_fire && !w_err && (w_idx == IDXW'(i));
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      assign reg_nxt[i][b*8 +: 8] =
          (wr_sel && bus.w_strb[b]) ? bus.w_data[b*8 +: 8] :
          HwWrEn_SI[i]              ? HwWrData_DI[i*AXI_DATA_WIDTH + b*8 +: 8] :
                                      regs[i][b*8 +: 8];
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      regs <= '0;
    end else begin
      regs <= reg_nxt;
    end
  end

  assign Reg_DO = regs;

endmodule

// File: tb/tb_axi_lite_reg_file.sv
// tb/tb_axi_lite_reg_file.sv - directed self-checking bench for axi_lite_reg_file

module tb_axi_lite_reg_file;
  import axi_lite_pkg::*;

  localparam int NR = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NR-1:0]   hw_en = '0;
  logic [NR*32-1:0] hw_data = '0;
  logic [NR*32-1:0] reg_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [NR];

  axi_lite_reg_file_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_reg_file #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .NUM_REGS      (NR),
    .READ_ONLY_MASK(8'h01)
  ) dut (
    .Clk_CI     (clk),
    .Rst_RBI    (resetn),
    .bus        (bus),
    .HwWrEn_SI  (hw_en),
    .HwWrData_DI(hw_data),
    .Reg_DO     (reg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, reg_out[i*32 +: 32], exp_regs[i]);
  endtask

  // Write with optional B stall; during the stall a second write is offered
  // to reg6 and must not be accepted.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold,
                           output logic [1:0] resp);
    int n;
    bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.aw_ready && bus.w_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_handshake", bus.aw_ready && bus.w_ready, 1);
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; hw_en = '0;
    @(negedge clk);
    check("b_valid_lat", bus.b_valid, 1);
    resp = bus.b_resp;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      bus.aw_addr = 32'h18; bus.w_data = 32'hFFFF_FFFF; bus.w_strb = 4'hF;
      bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
      @(negedge clk);
      check("b_stall_valid", bus.b_valid, 1);
      check("b_stall_resp", bus.b_resp, resp);
      check("b_stall_awready", {bus.aw_ready, bus.w_ready}, 2'b00);
    end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    @(negedge clk);
    check("b_valid_drop", bus.b_valid, 0);
  endtask

  // Read with optional R stall; during the stall another AR is offered.
  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bus.ar_addr = addr; bus.ar_valid = 1'b1;
    @(negedge clk);
    check("ar_ready_idle", bus.ar_ready, 1);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    @(negedge clk);
    check("r_valid_lat", bus.r_valid, 1);
    data = bus.r_data;
    resp = bus.r_resp;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      bus.ar_addr = 32'h4; bus.ar_valid = 1'b1;
      @(negedge clk);
      check("r_stall_valid", bus.r_valid, 1);
      check("r_stall_data", bus.r_data, data);
      check("r_stall_resp", bus.r_resp, resp);
      check("r_stall_arready", bus.ar_ready, 0);
    end
    @(posedge clk); #1;
    bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
    @(posedge clk); #1;
    bus.r_ready = 1'b0;
    @(negedge clk);
    check("r_valid_drop", bus.r_valid, 0);
  endtask

  logic [1:0]  resp, rresp;
  logic [31:0] rdata;

  initial begin
    bus.aw_addr = '0; bus.aw_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0;
    bus.w_valid = 1'b0; bus.b_ready = 1'b0; bus.ar_addr = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;

    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_b_valid", bus.b_valid, 0);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_r_data", bus.r_data, 0);
    check("rst_b_resp", bus.b_resp, 0);
    check_regs("rst_regs");

    // Read reg3 after reset
    @(posedge clk); #1;
    axi_read(32'hC, 0, rdata, rresp);
    check("rd3_data", rdata, 32'h0);
    check("rd3_resp", rresp, RESP_OKAY);

    // Byte-strobe merge into reg2
    @(posedge clk); #1;
    axi_write(32'h8, 32'h1122_3344, 4'hF, 0, resp);
    check("wr2_full_resp", resp, RESP_OKAY);
    @(posedge clk); #1;
    axi_write(32'h8, 32'hDEAD_BEEF, 4'b0101, 0, resp);
    exp_regs[2] = 32'h11AD_33EF;
    check("wr2_strb_resp", resp, RESP_OKAY);
    check_regs("wr2_regs");
    @(posedge clk); #1;
    axi_read(32'h8, 0, rdata, rresp);
    check("rd2_data", rdata, 32'h11AD_33EF);

    // RO and out-of-range writes/reads
    @(posedge clk); #1;
    axi_write(32'h0, 32'h1234_5678, 4'hF, 0, resp);
    check("wr_ro_resp", resp, RESP_SLVERR);
    @(posedge clk); #1;
    axi_write(32'h40, 32'h1234_5678, 4'hF, 0, resp);
    check("wr_oor_resp", resp, RESP_SLVERR);
    check_regs("err_regs");
    @(posedge clk); #1;
    axi_read(32'h40, 0, rdata, rresp);
    check("rd_oor_data", rdata, 32'h0);
    check("rd_oor_resp", rresp, RESP_SLVERR);

    // Hardware load of RO reg0, then bus read of it
    @(posedge clk); #1;
    hw_en = 8'h01; hw_data[31:0] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hw_en = '0;
    exp_regs[0] = 32'hCAFE_F00D;
    check_regs("hw0_regs");
    axi_read(32'h0, 0, rdata, rresp);
    check("rd_ro_data", rdata, 32'hCAFE_F00D);
    check("rd_ro_resp", rresp, RESP_OKAY);

    // AW presented 3 cycles before W
    @(posedge clk); #1;
    bus.aw_addr = 32'h14; bus.aw_valid = 1'b1; bus.w_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("aw_only_ready", {bus.aw_ready, bus.w_ready}, 2'b00);
      @(posedge clk); #1;
    end
    axi_write(32'h14, 32'hA5A5_A5A5, 4'hF, 0, resp);
    exp_regs[5] = 32'hA5A5_A5A5;
    check("aw_early_resp", resp, RESP_OKAY);
    check_regs("aw_early_regs");

    // B and R stalls of 5 cycles
    @(posedge clk); #1;
    axi_write(32'h10, 32'h0102_0304, 4'hF, 5, resp);
    exp_regs[4] = 32'h0102_0304;
    check("stall_wr_resp", resp, RESP_OKAY);
    check_regs("stall_wr_regs");
    @(posedge clk); #1;
    axi_read(32'h10, 5, rdata, rresp);
    check("stall_rd_data", rdata, 32'h0102_0304);

    // Read and write to reg5 on the same edge: read sees the old value
    @(posedge clk); #1;
    fork
      axi_write(32'h14, 32'h5A5A_5A5A, 4'hF, 0, resp);
      axi_read(32'h14, 0, rdata, rresp);
    join
    exp_regs[5] = 32'h5A5A_5A5A;
    check("rw_same_rdata", rdata, 32'hA5A5_A5A5);
    check_regs("rw_same_regs");

    // Hardware load and bus write to reg1 on the same edge
    @(posedge clk); #1;
    hw_en = 8'h02; hw_data[63:32] = 32'hFFFF_FFFF;
    axi_write(32'h4, 32'h0000_00AA, 4'b0001, 0, resp);
    exp_regs[1] = 32'hFFFF_FFAA;
    check("hw_bus_resp", resp, RESP_OKAY);
    check_regs("hw_bus_regs");

    // Reset while a write response is pending
    @(posedge clk); #1;
    bus.aw_addr = 32'hC; bus.w_data = 32'h7777_7777; bus.w_strb = 4'hF;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("pre_rst_b_valid", bus.b_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    check("mid_rst_b_valid", bus.b_valid, 0);
    check_regs("mid_rst_regs");
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
